// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared widths, state encoding and state-decode helpers for
// the instruction-memory boot loader. Optional feature macro used by the top:
// IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

   localparam int LEN_W  = 16;   // width of the image word-count header
   localparam int BYTE_W = 8;    // stream byte width
   localparam int WORD_W = 32;   // IMEM word width

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LEN0 = 3'd1,
      LEN1 = 3'd2,
      DATA = 3'd3,
      CSUM = 3'd4,
      DONE = 3'd5,
      ERR  = 3'd6
   } state_e;

   // True for every state in which a load is in progress.
   function automatic logic is_busy_state(input state_e st);
      logic busy_v;
      case (st)
         LEN0, LEN1, DATA, CSUM: busy_v = 1'b1;
         default:                busy_v = 1'b0;
      endcase
      return busy_v;
   endfunction

   // True for the states in which a start pulse begins a new load.
   function automatic logic accepts_start(input state_e st);
      logic ok_v;
      case (st)
         IDLE, DONE, ERR: ok_v = 1'b1;
         default:         ok_v = 1'b0;
      endcase
      return ok_v;
   endfunction

endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: assembles a little-endian byte stream into 32-bit words.
// The first three bytes of a word are held in acc_r; on the fourth byte the
// completed word is presented combinationally together with a one-cycle
// word_valid pulse, so the caller can register it in the same edge.
module imem_word_packer
   import imem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              byte_valid,
   input  logic [BYTE_W-1:0] byte_data,
   output logic              word_valid,
   output logic [WORD_W-1:0] word
);

   logic [1:0]               byte_cnt_r;
   logic [WORD_W-BYTE_W-1:0] acc_r;

   // Byte-lane counter and storage of the three low bytes of the current word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt_r <= 2'd0;
         acc_r      <= 24'h00_0000;
      end else if (clear) begin
         byte_cnt_r <= 2'd0;
         acc_r      <= 24'h00_0000;
      end else if (byte_valid) begin
         case (byte_cnt_r)
            2'd0:    acc_r[7:0]   <= byte_data;
            2'd1:    acc_r[15:8]  <= byte_data;
            2'd2:    acc_r[23:16] <= byte_data;
            default: acc_r        <= acc_r;
         endcase
         // lane 3 rolls over to lane 0: the word is complete
         byte_cnt_r <= byte_cnt_r + 2'd1;
      end else begin
         byte_cnt_r <= byte_cnt_r;
         acc_r      <= acc_r;
      end
   end

   // Present the completed word while its top byte is on the input
   always_comb begin
      word_valid = byte_valid && !clear && (byte_cnt_r == 2'd3);
      word       = {byte_data, acc_r};
   end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory programmer.
// Accepts a byte stream made of a 16-bit little-endian word count N followed by
// N little-endian 32-bit words, writes them to IMEM from BASE_ADDR upward and
// holds the core in reset until the whole image is in place.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing
// 32-bit word equal to the XOR of all payload words before DONE is reached.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
   parameter int          DEPTH     = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        s_valid,
   input  logic [7:0]  s_data,
   output logic        s_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        cpu_rst_n,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam int CNT_W = $clog2(DEPTH + 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_e POST_DATA = CSUM;
`else
   localparam state_e POST_DATA = DONE;
`endif

   state_e              state_r;
   state_e              next_state_s;

   logic [BYTE_W-1:0]   len_lo_r;
   logic [LEN_W-1:0]    len_s;
   logic                len_ok_s;
   logic [CNT_W-1:0]    word_cnt_r;

   logic                accept_s;
   logic                start_ok_s;
   logic                pk_in_s;
   logic                pk_valid_s;
   logic [WORD_W-1:0]   pk_word_s;
   logic                last_byte_s;
   logic                last_write_s;
   logic                ready_next_s;
   logic                csum_match_s;

   logic                s_ready_r;
   logic                imem_we_r;
   logic [31:0]         imem_addr_r;
   logic [31:0]         imem_wdata_r;
   logic                cpu_rst_n_r;
   logic                busy_r;
   logic                done_r;
   logic                error_r;

   // The packer restarts at lane 0 whenever a new load begins.
   imem_word_packer u_packer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (start_ok_s),
      .byte_valid (pk_in_s),
      .byte_data  (s_data),
      .word_valid (pk_valid_s),
      .word       (pk_word_s)
   );

   // Handshake, header and word-count qualifiers
   always_comb begin
      accept_s     = s_valid && s_ready_r;
      start_ok_s   = start && accepts_start(state_r);
      len_s        = {s_data, len_lo_r};
      len_ok_s     = (len_s <= LEN_W'(DEPTH));
      pk_in_s      = accept_s && ((state_r == DATA) || (state_r == CSUM));
      // the 4th byte of the final word: stop taking bytes during its write cycle
      last_byte_s  = (state_r == DATA) && pk_valid_s && (word_cnt_r == CNT_W'(1));
      last_write_s = imem_we_r && (word_cnt_r == CNT_W'(1));
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [WORD_W-1:0] csum_r;

   // Running XOR of every payload word of the current load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum_r <= 32'h0000_0000;
      end else if (start_ok_s) begin
         csum_r <= 32'h0000_0000;
      end else if ((state_r == DATA) && pk_valid_s) begin
         csum_r <= csum_r ^ pk_word_s;
      end else begin
         csum_r <= csum_r;
      end
   end

   // Trailing checksum word compared against the running XOR
   always_comb begin
      csum_match_s = (pk_word_s == csum_r);
   end
`else
   // No checksum stage in this build
   always_comb begin
      csum_match_s = 1'b0;
   end
`endif

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE, DONE, ERR: begin
            if (start_ok_s) begin
               next_state_s = LEN0;
            end else begin
               next_state_s = state_r;
            end
         end
         LEN0: begin
            if (accept_s) begin
               next_state_s = LEN1;
            end else begin
               next_state_s = LEN0;
            end
         end
         LEN1: begin
            if (!accept_s) begin
               next_state_s = LEN1;
            end else if (len_s == {LEN_W{1'b0}}) begin
               next_state_s = POST_DATA;
            end else if (!len_ok_s) begin
               next_state_s = ERR;
            end else begin
               next_state_s = DATA;
            end
         end
         DATA: begin
            if (last_write_s) begin
               next_state_s = POST_DATA;
            end else begin
               next_state_s = DATA;
            end
         end
         CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (!pk_valid_s) begin
               next_state_s = CSUM;
            end else if (csum_match_s) begin
               next_state_s = DONE;
            end else begin
               next_state_s = ERR;
            end
`else
            // unreachable without the checksum stage; fail safe
            next_state_s = ERR;
`endif
         end
         default: next_state_s = IDLE;
      endcase
   end

   // Low header byte capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_lo_r <= 8'h00;
      end else if ((state_r == LEN0) && accept_s) begin
         len_lo_r <= s_data;
      end else begin
         len_lo_r <= len_lo_r;
      end
   end

   // Remaining-word counter: loaded from the header, decremented per write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r == LEN1) && accept_s && len_ok_s) begin
         word_cnt_r <= len_s[CNT_W-1:0];
      end else if (imem_we_r) begin
         word_cnt_r <= word_cnt_r - CNT_W'(1);
      end else begin
         word_cnt_r <= word_cnt_r;
      end
   end

   // IMEM write port: strobe, data and post-incremented word address
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         imem_we_r    <= 1'b0;
         imem_addr_r  <= BASE_ADDR;
         imem_wdata_r <= 32'h0000_0000;
      end else begin
         imem_we_r <= (state_r == DATA) && pk_valid_s;
         if ((state_r == DATA) && pk_valid_s) begin
            imem_wdata_r <= pk_word_s;
         end else begin
            imem_wdata_r <= imem_wdata_r;
         end
         if (start_ok_s) begin
            imem_addr_r <= BASE_ADDR;
         end else if (imem_we_r) begin
            imem_addr_r <= imem_addr_r + 32'd4;
         end else begin
            imem_addr_r <= imem_addr_r;
         end
      end
   end

   // Stream-ready decode for the coming cycle
   always_comb begin
      ready_next_s = is_busy_state(next_state_s) && !last_byte_s;
   end

   // Status and control outputs registered from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_ready_r   <= 1'b0;
         cpu_rst_n_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         error_r     <= 1'b0;
      end else begin
         s_ready_r   <= ready_next_s;
         cpu_rst_n_r <= (next_state_s == DONE);
         busy_r      <= is_busy_state(next_state_s);
         done_r      <= (next_state_s == DONE);
         error_r     <= (next_state_s == ERR);
      end
   end

   assign s_ready    = s_ready_r;
   assign imem_we    = imem_we_r;
   assign imem_addr  = imem_addr_r;
   assign imem_wdata = imem_wdata_r;
   assign cpu_rst_n  = cpu_rst_n_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign error      = error_r;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader.
// Stimulus changes and checks happen on the falling clock edge; IMEM writes
// are captured on the falling edge into queues and compared with hand-written
// expected words and addresses.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        s_valid;
   logic [7:0]  s_data;
   logic        s_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_rst_n;
   logic        busy;
   logic        done;
   logic        error;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   logic [31:0] exp_w [0:63];

   always #5 clk = ~clk;

   imem_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .s_valid    (s_valid),
      .s_data     (s_data),
      .s_ready    (s_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_rst_n  (cpu_rst_n),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   // capture every IMEM write strobe
   always @(negedge clk) begin
      if (rst_n === 1'b1 && imem_we === 1'b1) begin
         wr_addr_q.push_back(imem_addr);
         wr_data_q.push_back(imem_wdata);
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int waited;
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      s_valid = 1'b1;
      s_data  = b;
      waited  = 0;
      while (s_ready !== 1'b1 && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 40) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_byte_timeout: s_ready=%b, required 1 within 40 cycles", s_ready);
      end
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input bit gaps);
      send_byte(w[7:0], gaps);
      send_byte(w[15:8], gaps);
      send_byte(w[23:16], gaps);
      send_byte(w[31:24], gaps);
   endtask

   task automatic start_pulse();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_end(input string name);
      int waited;
      waited = 0;
      while (done !== 1'b1 && error !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      n_cmp++;
      if (waited >= 20) begin
         n_bad++;
         $display("FAIL %s_end: done=%b error=%b, required one of them within 20 cycles", name, done, error);
      end
   endtask

   task automatic run_load(input int n, input bit gaps);
      logic [15:0] n16;
`ifdef IMEM_LOADER_CHECKSUM_EN
      logic [31:0] x;
      x = 32'h0000_0000;
`endif
      n16 = 16'(n);
      start_pulse();
      send_byte(n16[7:0], gaps);
      send_byte(n16[15:8], gaps);
      for (int i = 0; i < n; i++) begin
         send_word(exp_w[i], gaps);
`ifdef IMEM_LOADER_CHECKSUM_EN
         x = x ^ exp_w[i];
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_word(x, gaps);
`endif
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
      repeat (2) @(negedge clk);
      n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL reset_s_ready: got %b need 0", s_ready); end
      n_cmp++; if (imem_we !== 1'b0) begin n_bad++; $display("FAIL reset_imem_we: got %b need 0", imem_we); end
      n_cmp++; if (imem_addr !== 32'h0000_1000) begin n_bad++; $display("FAIL reset_addr: got %h need 00001000", imem_addr); end
      n_cmp++; if (imem_wdata !== 32'h0000_0000) begin n_bad++; $display("FAIL reset_wdata: got %h need 0", imem_wdata); end
      n_cmp++; if ({cpu_rst_n, busy, done, error} !== 4'b0000) begin n_bad++; $display("FAIL reset_status: got %b need 0000", {cpu_rst_n, busy, done, error}); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if ({s_ready, busy, cpu_rst_n} !== 3'b000) begin n_bad++; $display("FAIL idle_status: got %b need 000", {s_ready, busy, cpu_rst_n}); end
   endtask

   task automatic test_load4();
      wr_addr_q.delete(); wr_data_q.delete();
      exp_w[0] = 32'hFFC4_A303; exp_w[1] = 32'h0064_A423;
      exp_w[2] = 32'h0062_E233; exp_w[3] = 32'hFE42_0AE3;
      start_pulse();
      n_cmp++; if ({busy, cpu_rst_n, s_ready} !== 3'b101) begin n_bad++; $display("FAIL load4_started: busy,cpu_rst_n,s_ready got %b need 101", {busy, cpu_rst_n, s_ready}); end
      send_byte(8'h04, 1'b0);
      send_byte(8'h00, 1'b0);
      send_word(exp_w[0], 1'b0);
      start_pulse();   // ignored: load in progress
      for (int i = 1; i < 4; i++) send_word(exp_w[i], 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_word(32'h0180_EFF0, 1'b0);
`endif
      wait_end("load4");
      n_cmp++; if (wr_addr_q.size() !== 4) begin n_bad++; $display("FAIL load4_count: got %0d writes need 4", wr_addr_q.size()); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (i >= wr_addr_q.size() || wr_addr_q[i] !== 32'h0000_1000 + 32'(4 * i) || wr_data_q[i] !== exp_w[i]) begin
            n_bad++;
            $display("FAIL load4_write%0d: got %h@%h need %h@%h", i,
                     (i < wr_data_q.size()) ? wr_data_q[i] : 32'hx, (i < wr_addr_q.size()) ? wr_addr_q[i] : 32'hx,
                     exp_w[i], 32'h0000_1000 + 32'(4 * i));
         end
      end
      n_cmp++; if ({done, error, cpu_rst_n, busy, s_ready} !== 5'b10100) begin n_bad++; $display("FAIL load4_status: done,error,cpu_rst_n,busy,s_ready got %b need 10100", {done, error, cpu_rst_n, busy, s_ready}); end
      n_cmp++; if (imem_addr !== 32'h0000_1010) begin n_bad++; $display("FAIL load4_final_addr: got %h need 00001010", imem_addr); end
   endtask

   task automatic test_empty();
      wr_addr_q.delete(); wr_data_q.delete();
      start_pulse();
      n_cmp++; if ({done, cpu_rst_n, busy} !== 3'b001) begin n_bad++; $display("FAIL empty_restart: done,cpu_rst_n,busy got %b need 001", {done, cpu_rst_n, busy}); end
      n_cmp++; if (imem_addr !== 32'h0000_1000) begin n_bad++; $display("FAIL empty_addr_rewind: got %h need 00001000", imem_addr); end
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL empty_wait_csum: done got %b need 0", done); end
      send_word(32'h0000_0000, 1'b0);
`endif
      n_cmp++; if ({done, error, cpu_rst_n} !== 3'b101) begin n_bad++; $display("FAIL empty_done: done,error,cpu_rst_n got %b need 101", {done, error, cpu_rst_n}); end
      n_cmp++; if (wr_addr_q.size() !== 0) begin n_bad++; $display("FAIL empty_writes: got %0d need 0", wr_addr_q.size()); end
   endtask

   task automatic test_too_long();
      wr_addr_q.delete(); wr_data_q.delete();
      start_pulse();
      send_byte(8'h41, 1'b0);
      send_byte(8'h00, 1'b0);
      n_cmp++; if ({error, done, cpu_rst_n, s_ready, busy} !== 5'b10000) begin n_bad++; $display("FAIL toolong_status: error,done,cpu_rst_n,s_ready,busy got %b need 10000", {error, done, cpu_rst_n, s_ready, busy}); end
      s_valid = 1'b1; s_data = 8'h55;   // not consumed while s_ready is low
      repeat (4) @(negedge clk);
      s_valid = 1'b0;
      n_cmp++; if ({error, s_ready} !== 2'b10) begin n_bad++; $display("FAIL toolong_hold: error,s_ready got %b need 10", {error, s_ready}); end
      n_cmp++; if (wr_addr_q.size() !== 0) begin n_bad++; $display("FAIL toolong_writes: got %0d need 0", wr_addr_q.size()); end
   endtask

   task automatic test_max_depth();
      wr_addr_q.delete(); wr_data_q.delete();
      for (int i = 0; i < 64; i++) exp_w[i] = {4{8'(i + 16)}};
      run_load(64, 1'b0);
      wait_end("depth64");
      n_cmp++; if (wr_addr_q.size() !== 64) begin n_bad++; $display("FAIL depth64_count: got %0d need 64", wr_addr_q.size()); end
      n_cmp++;
      if (wr_addr_q.size() != 64 || wr_addr_q[63] !== 32'h0000_10FC || wr_data_q[63] !== 32'h4F4F_4F4F) begin
         n_bad++;
         $display("FAIL depth64_last: got %0d writes, need last 4f4f4f4f@000010fc", wr_addr_q.size());
      end
      n_cmp++; if ({done, error, imem_addr} !== {2'b10, 32'h0000_1100}) begin n_bad++; $display("FAIL depth64_final: done,error,addr got %b %b %h need 1 0 00001100", done, error, imem_addr); end
   endtask

   task automatic test_random_gaps();
      exp_w[0] = 32'h0000_0013; exp_w[1] = 32'h1234_5678; exp_w[2] = 32'hCAFE_F00D; exp_w[3] = 32'h8000_0001;
      exp_w[4] = 32'h00FF_00FF; exp_w[5] = 32'hA5A5_5A5A; exp_w[6] = 32'h0BAD_C0DE; exp_w[7] = 32'hFFFF_FFFF;
      for (int p = 0; p < 2; p++) begin
         wr_addr_q.delete(); wr_data_q.delete();
         run_load(8, p[0]);
         wait_end("gaps");
         n_cmp++; if (wr_addr_q.size() !== 8) begin n_bad++; $display("FAIL gaps%0d_count: got %0d need 8", p, wr_addr_q.size()); end
         for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (i >= wr_addr_q.size() || wr_addr_q[i] !== 32'h0000_1000 + 32'(4 * i) || wr_data_q[i] !== exp_w[i]) begin
               n_bad++;
               $display("FAIL gaps%0d_write%0d: need %h@%h, got %0d writes", p, i, exp_w[i], 32'h0000_1000 + 32'(4 * i), wr_addr_q.size());
            end
         end
         n_cmp++; if ({done, error, cpu_rst_n} !== 3'b101) begin n_bad++; $display("FAIL gaps%0d_status: done,error,cpu_rst_n got %b need 101", p, {done, error, cpu_rst_n}); end
      end
   endtask

   task automatic test_reset_midload();
      start_pulse();
      send_byte(8'h02, 1'b0);
      send_byte(8'h00, 1'b0);
      send_word(32'h1122_3344, 1'b0);
      send_byte(8'h66, 1'b0);
      send_byte(8'h77, 1'b0);
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({s_ready, imem_we, cpu_rst_n, busy, done, error} !== 6'b000000) begin n_bad++; $display("FAIL midreset_status: got %b need 000000", {s_ready, imem_we, cpu_rst_n, busy, done, error}); end
      n_cmp++; if (imem_addr !== 32'h0000_1000 || imem_wdata !== 32'h0000_0000) begin n_bad++; $display("FAIL midreset_port: got %h/%h need 00001000/00000000", imem_addr, imem_wdata); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      wr_addr_q.delete(); wr_data_q.delete();
      exp_w[0] = 32'hDEAD_BEEF;
      run_load(1, 1'b0);
      wait_end("midreset");
      n_cmp++;
      if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 32'h0000_1000 || wr_data_q[0] !== 32'hDEAD_BEEF) begin
         n_bad++;
         $display("FAIL midreset_reload: got %0d writes, need one deadbeef@00001000", wr_addr_q.size());
      end
      n_cmp++; if ({done, cpu_rst_n, imem_addr} !== {2'b11, 32'h0000_1004}) begin n_bad++; $display("FAIL midreset_done: done,cpu_rst_n,addr got %b %b %h need 1 1 00001004", done, cpu_rst_n, imem_addr); end
   endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      for (int p = 0; p < 2; p++) begin
         wr_addr_q.delete(); wr_data_q.delete();
         start_pulse();
         send_byte(8'h02, 1'b0);
         send_byte(8'h00, 1'b0);
         send_word(32'h0000_0001, 1'b0);
         send_word(32'h0000_0002, 1'b0);
         send_word((p == 0) ? 32'h0000_0003 : 32'h0000_0004, 1'b0);
         wait_end("csum");
         n_cmp++; if (wr_addr_q.size() !== 2) begin n_bad++; $display("FAIL csum%0d_count: got %0d need 2", p, wr_addr_q.size()); end
         n_cmp++;
         if ({done, error, cpu_rst_n} !== ((p == 0) ? 3'b101 : 3'b010)) begin
            n_bad++;
            $display("FAIL csum%0d_status: done,error,cpu_rst_n got %b need %b", p, {done, error, cpu_rst_n}, (p == 0) ? 3'b101 : 3'b010);
         end
         n_cmp++; if (imem_addr !== 32'h0000_1008) begin n_bad++; $display("FAIL csum%0d_addr: got %h need 00001008", p, imem_addr); end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_load4();
      test_empty();
      test_too_long();
      test_max_depth();
      test_random_gaps();
      test_reset_midload();
`ifdef IMEM_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
